// File: rtl/ula.sv
// ula: 8-bit ALU. It has add/sub/and/or/not/xor/shl/shr modes, a registered result and four status flags.
// Latency: 1 cycle. The outputs after edge N reflect a/b/mode sampled at edge N.
// Backpressure: none. It accepts a new operation on every rising edge and has no enable.
module ula #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       mode,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             zero,
    output logic             negative,
    output logic             overflow
);

    localparam logic [3:0] MODE_ADD = 4'b0000;
    localparam logic [3:0] MODE_SUB = 4'b0001;
    localparam logic [3:0] MODE_AND = 4'b0010;
    localparam logic [3:0] MODE_OR  = 4'b0011;
    localparam logic [3:0] MODE_NOT = 4'b0100;
    localparam logic [3:0] MODE_XOR = 4'b0101;
    localparam logic [3:0] MODE_SHL = 4'b0110;
    localparam logic [3:0] MODE_SHR = 4'b0111;

    // The extra top bit of the 9-bit sum is the carry out.
    // The extra top bit of the 9-bit difference is the borrow.
    logic [WIDTH:0]   sum_ext;
    logic [WIDTH:0]   diff_ext;
    logic [WIDTH-1:0] res_nxt;
    logic             carry_nxt;
    logic             ovf_nxt;

    assign sum_ext  = {1'b0, a} + {1'b0, b};
    assign diff_ext = {1'b0, a} - {1'b0, b};

    // Select the operation result and its carry/overflow.
    // Modes that do not define a flag leave it at 0.
    always_comb begin
        res_nxt   = '0;
        carry_nxt = 1'b0;
        ovf_nxt   = 1'b0;
        case (mode)
            MODE_ADD: begin
                res_nxt   = sum_ext[WIDTH-1:0];
                carry_nxt = sum_ext[WIDTH];
                ovf_nxt   = (a[WIDTH-1] == b[WIDTH-1]) &&
                            (sum_ext[WIDTH-1] != a[WIDTH-1]);
            end
            MODE_SUB: begin
                res_nxt   = diff_ext[WIDTH-1:0];
                carry_nxt = diff_ext[WIDTH];
                ovf_nxt   = (a[WIDTH-1] != b[WIDTH-1]) &&
                            (diff_ext[WIDTH-1] != a[WIDTH-1]);
            end
            MODE_AND: res_nxt = a & b;
            MODE_OR:  res_nxt = a | b;
            MODE_NOT: res_nxt = ~a;
            MODE_XOR: res_nxt = a ^ b;
            MODE_SHL: begin
                res_nxt   = {a[WIDTH-2:0], 1'b0};
                carry_nxt = a[WIDTH-1];
            end
            MODE_SHR: begin
                res_nxt   = {1'b0, a[WIDTH-1:1]};
                carry_nxt = a[0];
            end
            default: res_nxt = '0;
        endcase
    end

    // Register the result and flags on every edge.
    // Reset forces the "zero result" state immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result   <= '0;
            carry    <= 1'b0;
            zero     <= 1'b1;
            negative <= 1'b0;
            overflow <= 1'b0;
        end else begin
            result   <= res_nxt;
            carry    <= carry_nxt;
            zero     <= (res_nxt == '0);
            negative <= res_nxt[WIDTH-1];
            overflow <= ovf_nxt;
        end
    end

endmodule

// File: tb/tb_ula.sv
// Scoreboard bench for ula.
// The stimulus pushes expected outputs from an integer reference model.
// The monitor compares them one edge later.
module tb_ula;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] a, b;
    logic [3:0] mode;
    logic [7:0] result;
    logic       carry, zero, negative, overflow;

    typedef struct packed {
        logic [7:0] r;
        logic       c;
        logic       z;
        logic       n;
        logic       v;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];
    int    n_checks = 0;
    int    n_fail   = 0;

    ula #(.WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .a(a), .b(b), .mode(mode),
        .result(result), .carry(carry), .zero(zero),
        .negative(negative), .overflow(overflow)
    );

    always #5 clk = ~clk;

    function automatic int to_signed8(input int x);
        return (x >= 128) ? x - 256 : x;
    endfunction

    // Reference model: plain integer arithmetic following the mode table.
    function automatic exp_t model(input int ai, input int bi, input int m);
        exp_t e;
        int   s;
        int   sv;
        logic [7:0] av, bv;
        av = ai[7:0];
        bv = bi[7:0];
        e = '0;
        case (m)
            0: begin
                s = ai + bi;
                e.r = s[7:0];
                e.c = (s > 255);
                sv = to_signed8(ai) + to_signed8(bi);
                e.v = (sv > 127) || (sv < -128);
            end
            1: begin
                s = ai - bi;
                e.r = s[7:0];
                e.c = (ai < bi);
                sv = to_signed8(ai) - to_signed8(bi);
                e.v = (sv > 127) || (sv < -128);
            end
            2: e.r = av & bv;
            3: e.r = av | bv;
            4: begin s = 255 - ai; e.r = s[7:0]; end
            5: e.r = av ^ bv;
            6: begin s = (ai * 2) % 256; e.r = s[7:0]; e.c = (ai >= 128); end
            7: begin s = ai / 2; e.r = s[7:0]; e.c = (ai % 2 == 1); end
            default: e.r = 8'd0;
        endcase
        e.z = (e.r == 8'd0);
        e.n = (e.r >= 8'd128);
        return e;
    endfunction

    // Monitor: one registered output per edge while the scoreboard holds expectations.
    initial begin
        exp_t  e;
        string nm;
        forever begin
            @(posedge clk);
            #1;
            if (rst_n === 1'b1 && exp_q.size() > 0) begin
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                n_checks++;
                if ({result, carry, zero, negative, overflow} !== e) begin
                    n_fail++;
                    $display("FAIL %s: got r=%0d c=%b z=%b n=%b v=%b, expected r=%0d c=%b z=%b n=%b v=%b",
                             nm, result, carry, zero, negative, overflow,
                             e.r, e.c, e.z, e.n, e.v);
                end
            end
        end
    end

    task automatic check_reset(input string nm);
        n_checks++;
        if (result !== 8'd0 || carry !== 1'b0 || zero !== 1'b1 ||
            negative !== 1'b0 || overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL %s: got r=%0d c=%b z=%b n=%b v=%b, expected r=0 c=0 z=1 n=0 v=0",
                     nm, result, carry, zero, negative, overflow);
        end
    endtask

    // Drive at the falling edge and optionally glitch the inputs before the final values.
    // After the capturing edge, queue the expected response.
    task automatic issue(input logic [7:0] ai, input logic [7:0] bi,
                         input logic [3:0] mi, input string nm, input bit glitch = 1'b0);
        @(negedge clk);
        if (glitch) begin
            a    = 8'($urandom);
            b    = 8'($urandom);
            mode = 4'($urandom);
            #2;
        end
        a    = ai;
        b    = bi;
        mode = mi;
        @(posedge clk);
        exp_q.push_back(model(int'(ai), int'(bi), int'(mi)));
        name_q.push_back(nm);
    endtask

    initial begin
        logic [7:0] ra, rb;
        logic [3:0] rm;
        int         wait_cycles;

        rst_n = 1'b1;
        a = 8'd5; b = 8'd3; mode = 4'd0;
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b0;
        #1 check_reset("reset_async_assert");
        @(posedge clk);
        #1 check_reset("reset_held_over_edge");
        @(negedge clk);
        rst_n = 1'b1;
        issue(8'd0, 8'd0, 4'b0000, "reset_release_add0");

        // ADD
        issue(8'd1,   8'd2,   4'b0000, "add_1_2");
        issue(8'd4,   8'd8,   4'b0000, "add_4_8");
        issue(8'd6,   8'd11,  4'b0000, "add_6_11");
        issue(8'd32,  8'd64,  4'b0000, "add_32_64");
        issue(8'd86,  8'd107, 4'b0000, "add_86_107_ovf");
        issue(8'd255, 8'd1,   4'b0000, "add_255_1_wrap");
        // SUB
        issue(8'd2,   8'd1,   4'b0001, "sub_2_1");
        issue(8'd8,   8'd4,   4'b0001, "sub_8_4");
        issue(8'd11,  8'd6,   4'b0001, "sub_11_6");
        issue(8'd64,  8'd32,  4'b0001, "sub_64_32");
        issue(8'd107, 8'd86,  4'b0001, "sub_107_86");
        issue(8'd0,   8'd0,   4'b0001, "sub_0_0");
        issue(8'd0,   8'd1,   4'b0001, "sub_0_1_borrow");
        // AND / OR
        issue(8'b10101010, 8'b00000000, 4'b0010, "and_aa_00");
        issue(8'b10101010, 8'b10101010, 4'b0010, "and_aa_aa");
        issue(8'b11111111, 8'b11111111, 4'b0010, "and_ff_ff");
        issue(8'b10101010, 8'b01010101, 4'b0010, "and_aa_55");
        issue(8'b10101010, 8'b00000000, 4'b0011, "or_aa_00");
        issue(8'b00000000, 8'b00000000, 4'b0011, "or_00_00");
        issue(8'b10101010, 8'b01010101, 4'b0011, "or_aa_55");
        // NOT A with random b, extensions, reserved
        issue(8'b00000000, 8'($urandom), 4'b0100, "not_00");
        issue(8'b11111111, 8'($urandom), 4'b0100, "not_ff");
        issue(8'b10101101, 8'($urandom), 4'b0100, "not_ad");
        issue(8'b11010110, 8'($urandom), 4'b0100, "not_d6");
        issue(8'b11110000, 8'b10101010, 4'b0101, "xor_f0_aa");
        issue(8'b10000001, 8'($urandom), 4'b0110, "shl_81");
        issue(8'b00000011, 8'($urandom), 4'b0111, "shr_03");
        issue(8'($urandom), 8'($urandom), 4'b1010, "reserved_1010");

        // Back-to-back random ops across all modes, some with mid-cycle input glitches.
        for (int i = 0; i < 300; i++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            rm = 4'($urandom_range(0, 15));
            issue(ra, rb, rm, $sformatf("rand%0d_m%0d_a%0d_b%0d", i, rm, ra, rb),
                  ($urandom_range(0, 3) == 0));
        end

        // Assert reset mid-stream. The result captured at the last edge must vanish.
        issue(8'd200, 8'd100, 4'b0000, "pre_midreset_add");
        #4 rst_n = 1'b0;
        exp_q.delete();
        name_q.delete();
        #1 check_reset("reset_midstream");
        @(negedge clk);
        rst_n = 1'b1;
        issue(8'd7, 8'd9, 4'b0001, "post_reset_sub");
        issue(8'd127, 8'd1, 4'b0000, "post_reset_add_ovf");

        wait_cycles = 0;
        while (exp_q.size() > 0 && wait_cycles < 10) begin
            @(posedge clk);
            wait_cycles++;
        end
        #2;
        if (exp_q.size() > 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
